// File: rtl/count_down_timer.sv
// count_down_timer: HH:MM:SS BCD countdown for the digital-clock datapath.
// A preset is loaded, then decremented once per prescaler tick until it
// reaches 00:00:00, at which point ring is raised.
// Optional build macro: COUNT_DOWN_TIMER_RING_TIMEOUT_EN
//   defined     -> ring drops after RING_CYCLES clocks in DONE, state goes IDLE
//   not defined -> ring holds until set_timer, reset_timer or rst_n
//
// state  | meaning
// S_IDLE | not counting (zero preset, after reset, or after ring timeout)
// S_RUN  | counting down on prescaler ticks
// S_DONE | expired, count held at 00:00:00, ring high
module count_down_timer #(
    parameter int TICK_DIV    = 100_000_000,
    parameter int RING_CYCLES = 300_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_timer,
    input  logic       reset_timer,
    input  logic       pause,
    input  logic [7:0] hour_bcd_in,
    input  logic [7:0] minute_bcd_in,
    input  logic [7:0] second_bcd_in,
    output logic [7:0] hour_out_bcd,
    output logic [7:0] minute_out_bcd,
    output logic [7:0] second_out_bcd,
    output logic       ring
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_hh, r_mm, r_ss;
    logic [7:0]    r_pre_hh, r_pre_mm, r_pre_ss;
    logic          r_ring;

`ifdef COUNT_DOWN_TIMER_RING_TIMEOUT_EN
    localparam int RW = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
    localparam logic [RW-1:0] RING_LAST = RW'(RING_CYCLES - 1);
    logic [RW-1:0] r_ring_cnt;
`endif

    logic [7:0] w_clamp_hh, w_clamp_mm, w_clamp_ss;
    logic [7:0] w_dec_hh, w_dec_mm, w_dec_ss;
    logic       w_borrow_s, w_borrow_m;
    logic       w_clamp_zero, w_preset_zero, w_dec_zero;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Minutes and seconds are limited to 59 after per-digit clamping.
    function automatic logic [7:0] clamp_ms(input logic [7:0] v);
        logic [7:0] t;
        t = {clamp_digit(v[7:4]), clamp_digit(v[3:0])};
        return (t > 8'h59) ? 8'h59 : t;
    endfunction

    // Input clamping for set_timer.
    always_comb begin
        w_clamp_hh    = {clamp_digit(hour_bcd_in[7:4]), clamp_digit(hour_bcd_in[3:0])};
        w_clamp_mm    = clamp_ms(minute_bcd_in);
        w_clamp_ss    = clamp_ms(second_bcd_in);
        w_clamp_zero  = (w_clamp_hh == 8'h00) && (w_clamp_mm == 8'h00) && (w_clamp_ss == 8'h00);
        w_preset_zero = (r_pre_hh == 8'h00) && (r_pre_mm == 8'h00) && (r_pre_ss == 8'h00);
    end

    // One-second BCD decrement with borrow ss -> mm -> hh.
    always_comb begin
        w_borrow_s = (r_ss == 8'h00);
        if (r_ss == 8'h00)
            w_dec_ss = 8'h59;
        else if (r_ss[3:0] == 4'd0)
            w_dec_ss = {r_ss[7:4] - 4'd1, 4'd9};
        else
            w_dec_ss = r_ss - 8'd1;

        w_borrow_m = w_borrow_s && (r_mm == 8'h00);
        if (!w_borrow_s)
            w_dec_mm = r_mm;
        else if (r_mm == 8'h00)
            w_dec_mm = 8'h59;
        else if (r_mm[3:0] == 4'd0)
            w_dec_mm = {r_mm[7:4] - 4'd1, 4'd9};
        else
            w_dec_mm = r_mm - 8'd1;

        // hh never underflows: a zero count has already left RUN.
        if (!w_borrow_m || r_hh == 8'h00)
            w_dec_hh = r_hh;
        else if (r_hh[3:0] == 4'd0)
            w_dec_hh = {r_hh[7:4] - 4'd1, 4'd9};
        else
            w_dec_hh = r_hh - 8'd1;

        w_dec_zero = (w_dec_hh == 8'h00) && (w_dec_mm == 8'h00) && (w_dec_ss == 8'h00);
    end

    // Control FSM, prescaler, count and ring registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_hh       <= 8'h00;
            r_mm       <= 8'h00;
            r_ss       <= 8'h00;
            r_pre_hh   <= 8'h00;
            r_pre_mm   <= 8'h00;
            r_pre_ss   <= 8'h00;
            r_ring     <= 1'b0;
`ifdef COUNT_DOWN_TIMER_RING_TIMEOUT_EN
            r_ring_cnt <= '0;
`endif
        end else if (set_timer) begin
            r_pre_hh <= w_clamp_hh;
            r_pre_mm <= w_clamp_mm;
            r_pre_ss <= w_clamp_ss;
            r_hh     <= w_clamp_hh;
            r_mm     <= w_clamp_mm;
            r_ss     <= w_clamp_ss;
            r_presc  <= '0;
            r_ring   <= 1'b0;
            r_state  <= w_clamp_zero ? S_IDLE : S_RUN;
        end else if (reset_timer) begin
            r_hh     <= r_pre_hh;
            r_mm     <= r_pre_mm;
            r_ss     <= r_pre_ss;
            r_presc  <= '0;
            r_ring   <= 1'b0;
            r_state  <= w_preset_zero ? S_IDLE : S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (!pause) begin
                        if (r_presc == PRESC_LAST) begin
                            r_presc <= '0;
                            r_hh    <= w_dec_hh;
                            r_mm    <= w_dec_mm;
                            r_ss    <= w_dec_ss;
                            if (w_dec_zero) begin
                                r_state    <= S_DONE;
                                r_ring     <= 1'b1;
`ifdef COUNT_DOWN_TIMER_RING_TIMEOUT_EN
                                r_ring_cnt <= RING_LAST;
`endif
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                end
                S_DONE: begin
`ifdef COUNT_DOWN_TIMER_RING_TIMEOUT_EN
                    if (r_ring_cnt == '0) begin
                        r_ring  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_ring_cnt <= r_ring_cnt - RW'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign hour_out_bcd   = r_hh;
    assign minute_out_bcd = r_mm;
    assign second_out_bcd = r_ss;
    assign ring           = r_ring;

endmodule

// File: tb/tb_count_down_timer.sv
// Bench for count_down_timer with TICK_DIV=1 (one decrement per clk) and
// RING_CYCLES=4. Honours COUNT_DOWN_TIMER_RING_TIMEOUT_EN for ring expectations.
module tb_count_down_timer;

    logic       clk;
    logic       rst_n;
    logic       set_timer, reset_timer, pause;
    logic [7:0] hour_bcd_in, minute_bcd_in, second_bcd_in;
    logic [7:0] hour_out_bcd, minute_out_bcd, second_out_bcd;
    logic       ring;

    int n_err = 0;
    int n_chk = 0;

    count_down_timer #(.TICK_DIV(1), .RING_CYCLES(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .set_timer      (set_timer),
        .reset_timer    (reset_timer),
        .pause          (pause),
        .hour_bcd_in    (hour_bcd_in),
        .minute_bcd_in  (minute_bcd_in),
        .second_bcd_in  (second_bcd_in),
        .hour_out_bcd   (hour_out_bcd),
        .minute_out_bcd (minute_out_bcd),
        .second_out_bcd (second_out_bcd),
        .ring           (ring)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // op: 1 = set_timer, 2 = reset_timer, 3 = both asserted
    typedef struct {
        int         op;
        logic       pz;
        logic [7:0] h, m, s;
        int         wait_n;
        logic [7:0] eh, em, es;
        logic       er;
        string      name;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [7:0] eh, em, es, input logic er);
        n_chk++;
        if (hour_out_bcd !== eh || minute_out_bcd !== em || second_out_bcd !== es || ring !== er) begin
            n_err++;
            $display("FAIL %s: got %h:%h:%h ring=%b, expected %h:%h:%h ring=%b",
                     name, hour_out_bcd, minute_out_bcd, second_out_bcd, ring, eh, em, es, er);
        end
    endtask

    // Drive one load/reload edge, then let the count run for wait_n clocks.
    task automatic apply(input int op, input logic [7:0] h, m, s, input int wait_n);
        hour_bcd_in   = h;
        minute_bcd_in = m;
        second_bcd_in = s;
        set_timer     = op[0];
        reset_timer   = op[1];
        @(negedge clk);
        set_timer     = 1'b0;
        reset_timer   = 1'b0;
        repeat (wait_n) @(negedge clk);
    endtask

    initial begin
        vecs[0]  = '{1, 1'b0, 8'h01, 8'h30, 8'h15, 10, 8'h01, 8'h30, 8'h05, 1'b0, "run10"};
        vecs[1]  = '{1, 1'b0, 8'h01, 8'h00, 8'h00,  1, 8'h00, 8'h59, 8'h59, 1'b0, "hh_borrow"};
        vecs[2]  = '{1, 1'b0, 8'h00, 8'h10, 8'h00,  1, 8'h00, 8'h09, 8'h59, 1'b0, "mm_borrow"};
        vecs[3]  = '{1, 1'b0, 8'h00, 8'h99, 8'h7A,  0, 8'h00, 8'h59, 8'h59, 1'b0, "clamp_ms"};
        vecs[4]  = '{1, 1'b0, 8'h12, 8'h3F, 8'hA9,  0, 8'h12, 8'h39, 8'h59, 1'b0, "clamp_digit"};
        vecs[5]  = '{1, 1'b0, 8'h10, 8'h00, 8'h00,  1, 8'h09, 8'h59, 8'h59, 1'b0, "hh_bcd_borrow"};
        vecs[6]  = '{1, 1'b0, 8'h00, 8'h01, 8'h00,  2, 8'h00, 8'h00, 8'h58, 1'b0, "mm_to_zero"};
        vecs[7]  = '{1, 1'b0, 8'h00, 8'h00, 8'h20,  1, 8'h00, 8'h00, 8'h19, 1'b0, "ss_tens"};
        vecs[8]  = '{1, 1'b1, 8'h00, 8'h05, 8'h00,  3, 8'h00, 8'h05, 8'h00, 1'b0, "set_over_pause"};
        vecs[9]  = '{3, 1'b0, 8'h00, 8'h00, 8'h45,  0, 8'h00, 8'h00, 8'h45, 1'b0, "set_over_reset"};
        vecs[10] = '{2, 1'b0, 8'h00, 8'h00, 8'h00,  2, 8'h00, 8'h00, 8'h43, 1'b0, "reload_run"};
        vecs[11] = '{1, 1'b0, 8'h00, 8'h00, 8'h01,  1, 8'h00, 8'h00, 8'h00, 1'b1, "expire_1"};
        vecs[12] = '{1, 1'b0, 8'h00, 8'h00, 8'h00,  3, 8'h00, 8'h00, 8'h00, 1'b0, "zero_idle"};
        vecs[13] = '{1, 1'b0, 8'h99, 8'h59, 8'h59,  1, 8'h99, 8'h59, 8'h58, 1'b0, "max_preset"};

        rst_n = 1'b0;
        set_timer = 1'b0; reset_timer = 1'b0; pause = 1'b0;
        hour_bcd_in = 8'h00; minute_bcd_in = 8'h00; second_bcd_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_state", 8'h00, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_reset", 8'h00, 8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 14; i++) begin
            pause = vecs[i].pz;
            apply(vecs[i].op, vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].wait_n);
            check(vecs[i].name, vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].er);
            pause = 1'b0;
        end

        // Pause holds count and prescaler; counting resumes the next cycle.
        apply(1, 8'h01, 8'h29, 8'h55, 5);
        check("pre_pause", 8'h01, 8'h29, 8'h50, 1'b0);
        pause = 1'b1;
        repeat (5) @(negedge clk);
        check("paused_hold", 8'h01, 8'h29, 8'h50, 1'b0);
        pause = 1'b0;
        @(negedge clk);
        check("resume", 8'h01, 8'h29, 8'h49, 1'b0);

        // Expiry, ring behaviour, and no wrap below zero.
        apply(1, 8'h00, 8'h00, 8'h03, 2);
        check("before_expiry", 8'h00, 8'h00, 8'h01, 1'b0);
        @(negedge clk);
        check("expiry", 8'h00, 8'h00, 8'h00, 1'b1);
`ifdef COUNT_DOWN_TIMER_RING_TIMEOUT_EN
        repeat (3) @(negedge clk);
        check("ring_before_timeout", 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        check("ring_timeout", 8'h00, 8'h00, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        check("idle_after_timeout", 8'h00, 8'h00, 8'h00, 1'b0);
`else
        pause = 1'b1;
        repeat (5) @(negedge clk);
        pause = 1'b0;
        check("done_hold", 8'h00, 8'h00, 8'h00, 1'b1);
`endif
        apply(2, 8'h00, 8'h00, 8'h00, 0);
        check("reload_from_done", 8'h00, 8'h00, 8'h03, 1'b0);
        @(negedge clk);
        check("restart_after_reload", 8'h00, 8'h00, 8'h02, 1'b0);

        // Mid-run reload of the preset.
        apply(1, 8'h00, 8'h02, 8'h00, 5);
        check("mid_run", 8'h00, 8'h01, 8'h55, 1'b0);
        apply(2, 8'h00, 8'h00, 8'h00, 0);
        check("mid_run_reload", 8'h00, 8'h02, 8'h00, 1'b0);
        @(negedge clk);
        check("after_reload", 8'h00, 8'h01, 8'h59, 1'b0);

        // Asynchronous reset mid-count takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #1 check("async_reset", 8'h00, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_count_after_reset", 8'h00, 8'h00, 8'h00, 1'b0);
        apply(2, 8'h00, 8'h00, 8'h00, 3);
        check("preset_cleared", 8'h00, 8'h00, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
